keypad_scan: RTL
================

# keypad_scan

Scans a 4x4 active-low matrix keypad, debounces it, and presents one registered 4-bit key code with a one-cycle strobe per new press. It sits directly upstream of the command/memory-write stage of the maze design and is the sole source of that stage's `key_value` input. It drives columns, samples rows through a synchroniser, and rejects bounce and multi-key chords.

## Interface
- `SCAN_DIV`, 1000: clk cycles each column is driven; legal range >= 4.
- `DEBOUNCE_SCANS`, 4: consecutive identical full-scan results required to commit a press or release; legal range 1..15.
- `clk` input 1: single clock; all state changes on its rising edge.
- `nst` input 1: reset, asynchronous, active-low.
- `row_in` input 4: keypad rows, active-low, externally pulled up, asynchronous to `clk`.
- `col_out` output 4: column drive, active-low, exactly one bit low at all times.
- `key_value` output 4: committed key code = {row[1:0], col[1:0]}; holds its value until the next commit.
- `key_valid` output 1: one-cycle pulse when a new press is committed.
- `key_down` output 1: level, high while a committed key has not yet been released.

## Operation
- Reset (`nst`=0, immediate): `col_out`=4'b1110, `key_value`=0, `key_valid`=0, `key_down`=0, synchroniser=4'b1111, divider=0, column=0, previous result=NONE, stable count=0, state IDLE.
- Row path: 2-flop synchroniser; only the synchronised value is sampled.
- Divider counts 0..SCAN_DIV-1. On the terminal count, the block samples the synchronised rows for the current column, then advances the column 0->1->2->3->0. `col_out` = ~(1<<column).
- Per-scan accumulation:
  - A low row bit counts as one pressed key.
  - The code of the first key found is kept. Search order is ascending column, then ascending row within the column.
  - The key count saturates at 2.
- Scan result at column 3 sample: NONE (0 keys), KEY(code) (exactly 1 key), MULTI (>=2 keys). Accumulators then clear.
- Stability: if the result equals the previous result (including code), the stable count increments, saturating at DEBOUNCE_SCANS. Otherwise the count loads 1. The previous result is then updated.
- State machine, evaluated at end of each scan using the updated count:
  - IDLE -> PRESSED when the result is KEY(c) and count == DEBOUNCE_SCANS. On this transition: `key_value`<=c, `key_valid`<=1 for one cycle, `key_down`<=1.
  - PRESSED -> IDLE when the result is NONE and count == DEBOUNCE_SCANS. On this transition `key_down`<=0 and `key_value` is unchanged.
  - MULTI or a different KEY while PRESSED: remain PRESSED, no strobe. A new press requires a full debounced release.
  - MULTI in IDLE never commits.
- Assertion of `nst` mid-scan or mid-debounce discards all partial results. No `key_valid` is produced for the interrupted press.

## Timing
- Column dwell = SCAN_DIV cycles. Full scan period = 4*SCAN_DIV cycles.
- Row sample occurs at the dwell terminal count, at least 3 cycles after the column switch. This covers 2 synchroniser stages plus 1 settle cycle, which is why SCAN_DIV >= 4.
- `key_valid` and `key_down` rise on the clk edge after the column-3 sample of the committing scan. `key_value` updates on the same edge.
- Press-to-strobe latency, measured from a clean press stable before a scan start, is between DEBOUNCE_SCANS and DEBOUNCE_SCANS+1 scan periods, plus 1 cycle.
- Release-to-`key_down`-low latency uses the same bounds.
- `key_valid` is never high on two consecutive cycles. Minimum spacing between pulses is 2*DEBOUNCE_SCANS scans.

## Test plan
All scenarios use SCAN_DIV=4 and DEBOUNCE_SCANS=3, giving a scan period of 16 cycles.
- Reset: release `nst` with `row_in`=4'hF. Required: `col_out` cycles 1110,1101,1011,0111 every 4 cycles; `key_valid`, `key_down` and `key_value` stay 0 for 20 scans.
- Clean press of row 2, col 1 (pull `row_in`[2] low while `col_out`[1]=0), held 6 scans. Required: exactly one `key_valid` pulse with `key_value`=4'b1001, within 48-65 cycles of the first scan containing the press; `key_down`=1 thereafter.
- Bounce: toggle the same key on alternate scans for 8 scans, then hold. Required: no pulse during toggling; one pulse exactly 3 scans (plus 1 cycle) after the hold begins.
- Chord: row 0/col 0 and row 3/col 3 pressed together for 10 scans. Required: no `key_valid`. Release row 3/col 3 and keep row 0/col 0. Required: pulse with `key_value`=4'h0.
- Release and re-press: hold key 4'h6, release for 2 scans, press again. Required: no second pulse and `key_down` stays 1. Then release for 4 scans. Required: `key_down` falls and `key_value` stays 4'h6; the next press pulses again.
- Reset mid-debounce: pull `nst` low after 2 stable scans of key 4'hA. Required: all outputs zero immediately. After `nst` rises with the key still held, the pulse arrives 3 full scans later, not earlier.

Source files
------------

// File: rtl/keypad_scan.sv
// keypad_scan
//   Scans a 4x4 active-low matrix keypad and debounces it. It presents one
//   committed 4-bit key code and a single-cycle strobe for each new press.
//   Chords (two or more keys in one scan) are never committed.
//
// Parameters
//   SCAN_DIV        clk cycles each column is driven (>= 4)
//   DEBOUNCE_SCANS  consecutive identical scan results needed to commit (1..15)
//
// Ports
//   clk        single clock, rising edge
//   nst        asynchronous active-low reset
//   row_in     keypad rows, active-low, asynchronous to clk
//   col_out    column drive, active-low, exactly one bit low
//   key_value  committed key code {row[1:0], col[1:0]}, held until next commit
//   key_valid  one-cycle pulse on each committed press
//   key_down   high while the committed key has not been released
module keypad_scan #(
  parameter int SCAN_DIV       = 1000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic       clk,
  input  logic       nst,
  input  logic [3:0] row_in,
  output logic [3:0] col_out,
  output logic [3:0] key_value,
  output logic       key_valid,
  output logic       key_down
);

  localparam int             DIV_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [3:0]     DEB_MAX  = 4'(DEBOUNCE_SCANS);

  typedef enum logic [1:0] {RES_NONE = 2'd0, RES_KEY = 2'd1, RES_MULTI = 2'd2} result_t;
  typedef enum logic {ST_IDLE = 1'b0, ST_PRESSED = 1'b1} state_t;

  logic [3:0]       sync1_reg, sync2_reg;
  logic [DIV_W-1:0] div_reg;
  logic [1:0]       col_reg;
  logic [1:0]       acc_cnt_reg;
  logic [3:0]       acc_code_reg;
  result_t          res_kind_reg;
  logic [3:0]       res_code_reg;
  logic             res_valid_reg;
  result_t          prev_kind_reg;
  logic [3:0]       prev_code_reg;
  logic [3:0]       stable_reg, stable_next;
  state_t           state_reg, state_next;
  logic             commit, release_evt;
  logic [3:0]       key_value_reg;
  logic             key_valid_reg, key_down_reg;

  // Column drive is decoded straight from the column counter.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_col
      assign col_out[gi] = (col_reg != 2'(gi));
    end
  endgenerate

  // Per-column evaluation of the synchronised rows, merged into the scan
  // accumulator. Only the first key (lowest column, then lowest row) is kept.
  logic [1:0] col_lows;
  logic [1:0] col_row;
  logic       col_found;
  logic [2:0] acc_sum;
  logic [1:0] acc_cnt_next;
  logic [3:0] acc_code_next;
  result_t    scan_kind;
  logic [3:0] scan_code;

  always_comb begin
    col_lows  = 2'd0;
    col_row   = 2'd0;
    col_found = 1'b0;
    for (int r = 0; r < 4; r++) begin
      if (!sync2_reg[r]) begin
        if (!col_found) begin
          col_row   = 2'(r);
          col_found = 1'b1;
        end
        if (col_lows != 2'd2) col_lows = col_lows + 2'd1;
      end
    end
    acc_sum       = {1'b0, acc_cnt_reg} + {1'b0, col_lows};
    acc_cnt_next  = (acc_sum >= 3'd2) ? 2'd2 : acc_sum[1:0];
    acc_code_next = (acc_cnt_reg == 2'd0 && col_found) ? {col_row, col_reg} : acc_code_reg;
    scan_kind     = RES_NONE;
    scan_code     = 4'd0;
    case (acc_cnt_next)
      2'd0:    scan_kind = RES_NONE;
      2'd1:    begin scan_kind = RES_KEY; scan_code = acc_code_next; end
      default: scan_kind = RES_MULTI;
    endcase
  end

  // Synchroniser, dwell divider, column counter and scan accumulator. The
  // full-scan result is registered at the column-3 sample and consumed by
  // the debounce/FSM stage on the following cycle.
  always_ff @(posedge clk or negedge nst) begin
    if (!nst) begin
      sync1_reg     <= 4'hF;
      sync2_reg     <= 4'hF;
      div_reg       <= '0;
      col_reg       <= 2'd0;
      acc_cnt_reg   <= 2'd0;
      acc_code_reg  <= 4'd0;
      res_kind_reg  <= RES_NONE;
      res_code_reg  <= 4'd0;
      res_valid_reg <= 1'b0;
    end else begin
      sync1_reg     <= row_in;
      sync2_reg     <= sync1_reg;
      res_valid_reg <= 1'b0;
      if (div_reg == DIV_LAST) begin
        div_reg <= '0;
        col_reg <= col_reg + 2'd1;
        if (col_reg == 2'd3) begin
          res_kind_reg  <= scan_kind;
          res_code_reg  <= scan_code;
          res_valid_reg <= 1'b1;
          acc_cnt_reg   <= 2'd0;
          acc_code_reg  <= 4'd0;
        end else begin
          acc_cnt_reg  <= acc_cnt_next;
          acc_code_reg <= acc_code_next;
        end
      end else begin
        div_reg <= div_reg + DIV_W'(1);
      end
    end
  end

  // Stability counting and press/release state machine.
  always_comb begin
    stable_next = stable_reg;
    state_next  = state_reg;
    commit      = 1'b0;
    release_evt = 1'b0;
    if (res_valid_reg) begin
      if (res_kind_reg == prev_kind_reg && res_code_reg == prev_code_reg)
        stable_next = (stable_reg >= DEB_MAX) ? DEB_MAX : stable_reg + 4'd1;
      else
        stable_next = 4'd1;
      case (state_reg)
        ST_IDLE: begin
          if (res_kind_reg == RES_KEY && stable_next == DEB_MAX) begin
            state_next = ST_PRESSED;
            commit     = 1'b1;
          end
        end
        ST_PRESSED: begin
          // Only a debounced all-released scan re-arms; chords and other
          // keys are ignored while a key is held.
          if (res_kind_reg == RES_NONE && stable_next == DEB_MAX) begin
            state_next  = ST_IDLE;
            release_evt = 1'b1;
          end
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge nst) begin
    if (!nst) begin
      state_reg     <= ST_IDLE;
      stable_reg    <= 4'd0;
      prev_kind_reg <= RES_NONE;
      prev_code_reg <= 4'd0;
      key_value_reg <= 4'd0;
      key_valid_reg <= 1'b0;
      key_down_reg  <= 1'b0;
    end else begin
      state_reg     <= state_next;
      stable_reg    <= stable_next;
      key_valid_reg <= commit;
      if (res_valid_reg) begin
        prev_kind_reg <= res_kind_reg;
        prev_code_reg <= res_code_reg;
      end
      if (commit) begin
        key_value_reg <= res_code_reg;
        key_down_reg  <= 1'b1;
      end else if (release_evt) begin
        key_down_reg <= 1'b0;
      end
    end
  end

  assign key_value = key_value_reg;
  assign key_valid = key_valid_reg;
  assign key_down  = key_down_reg;

endmodule
